// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master: the sequencer (takes instruction fields and status, drives strobes).
// slave : the datapath side (drives instruction fields and status, takes strobes).
// Signals:
//   OpCode/funct - IR[31:26]/IR[5:0]
//   Zero         - ALU zero flag
//   MemReady     - memory access completes this cycle
//   PcWrite..AluCtrl - datapath control strobes and mux selects
//   IllegalOp    - DECODE pulse for an unsupported encoding
//   State        - current sequencer state (debug)
//   RetiredCnt   - retired-instruction count
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       OpCode;
  logic [5:0]       funct;
  logic             Zero;
  logic             MemReady;
  logic             PcWrite;
  logic             PcWriteCond;
  logic [1:0]       PcSource;
  logic             IorD;
  logic             IRWrite;
  logic             MemR;
  logic             MemW;
  logic             Mem2R;
  logic             RegW;
  logic             RegDst;
  logic             AluSrcA;
  logic [1:0]       AluSrcB;
  logic             ExtOp;
  logic [1:0]       AluCtrl;
  logic             IllegalOp;
  logic [3:0]       State;
  logic [CNT_W-1:0] RetiredCnt;

  modport master (
    input  OpCode, funct, Zero, MemReady,
    output PcWrite, PcWriteCond, PcSource, IorD, IRWrite, MemR, MemW,
           Mem2R, RegW, RegDst, AluSrcA, AluSrcB, ExtOp, AluCtrl,
           IllegalOp, State, RetiredCnt
  );

  modport slave (
    output OpCode, funct, Zero, MemReady,
    input  PcWrite, PcWriteCond, PcSource, IorD, IRWrite, MemR, MemW,
           Mem2R, RegW, RegDst, AluSrcA, AluSrcB, ExtOp, AluCtrl,
           IllegalOp, State, RetiredCnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle Moore control sequencer for the MIPS datapath.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous active-high reset (state FETCH, counter cleared)
//   bus   - multicycle_ctrl_if.master: instruction fields/status in, strobes out
//
// state  | meaning
// FETCH  | read IR from PC, PC += 4 when memory ready
// DECODE | precompute branch target, dispatch on opcode
// MEMADR | compute rs + sign-extended offset
// MEMRD  | load read, wait for memory
// MEMWB  | write loaded data to rt (retire)
// MEMWR  | store write, wait for memory (retire)
// EXEC   | R-type ALU op selected by funct
// RWB    | write ALUOut to rd (retire)
// BRANCH | compare rs/rt, conditional PC load (retire)
// JUMP   | PC <= jump target (retire)
// IEXEC  | immediate ALU op (addi/ori)
// IWB    | write ALUOut to rt (retire)
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR  = 4'd5, S_EXEC   = 4'd6, S_RWB   = 4'd7,
    S_BRANCH = 4'd8, S_JUMP  = 4'd9, S_IEXEC  = 4'd10, S_IWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pc_write, pc_write_cond, iord, ir_write, mem_r, mem_w;
  logic       mem2r, reg_w, reg_dst, alu_src_a, ext_op, illegal, retire;
  logic [1:0] pc_source, alu_src_b, alu_ctrl;
  logic       funct_ok;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign funct_ok = (bus.funct == FN_ADD) || (bus.funct == FN_SUB) ||
                    (bus.funct == FN_AND) || (bus.funct == FN_OR);

  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mem_r         = 1'b0;
    mem_w         = 1'b0;
    mem2r         = 1'b0;
    reg_w         = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_op        = 1'b0;
    alu_ctrl      = 2'b00;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_r     = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
        state_d   = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        case (bus.OpCode)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_IEXEC;
          OP_RTYPE: begin
            if (funct_ok) state_d = S_EXEC;
            else          illegal = 1'b1;
          end
          default:         illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        state_d   = (bus.OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_r   = 1'b1;
        iord    = 1'b1;
        state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_w   = 1'b1;
        mem2r   = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        mem_w   = 1'b1;
        iord    = 1'b1;
        retire  = bus.MemReady;
        state_d = bus.MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (bus.funct)
          FN_SUB:  alu_ctrl = 2'b01;
          FN_OR:   alu_ctrl = 2'b10;
          FN_AND:  alu_ctrl = 2'b11;
          default: alu_ctrl = 2'b00;
        endcase
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_w  = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.OpCode == OP_ORI) begin
          ext_op   = 1'b0;
          alu_ctrl = 2'b10;
        end else begin
          ext_op   = 1'b1;
          alu_ctrl = 2'b00;
        end
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_w   = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  // Write strobes are gated directly by Reset so an in-flight store or
  // register write is dropped the moment Reset rises, not at the next edge.
  assign bus.PcWrite     = pc_write & ~Reset;
  assign bus.PcWriteCond = pc_write_cond & ~Reset;
  assign bus.IRWrite     = ir_write & ~Reset;
  assign bus.RegW        = reg_w & ~Reset;
  assign bus.MemW        = mem_w & ~Reset;
  assign bus.IllegalOp   = illegal & ~Reset;
  assign bus.PcSource    = pc_source;
  assign bus.IorD        = iord;
  assign bus.MemR        = mem_r;
  assign bus.Mem2R       = mem2r;
  assign bus.RegDst      = reg_dst;
  assign bus.AluSrcA     = alu_src_a;
  assign bus.AluSrcB     = alu_src_b;
  assign bus.ExtOp       = ext_op;
  assign bus.AluCtrl     = alu_ctrl;
  assign bus.State       = state_q;
  assign bus.RetiredCnt  = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ORI = 6'b001101;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       last_retire;
  } step_t;

  logic Clk;
  logic Reset;
  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  step_t sb_q[$];

  wire [18:0] dut_vec = {bus.PcWrite, bus.PcWriteCond, bus.PcSource, bus.IorD,
                         bus.IRWrite, bus.MemR, bus.MemW, bus.Mem2R, bus.RegW,
                         bus.RegDst, bus.AluSrcA, bus.AluSrcB, bus.ExtOp,
                         bus.AluCtrl, bus.IllegalOp};

  // Reference output decode for a non-reset cycle.
  function automatic logic [18:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic [5:0] fn, input logic mr);
    logic pcw, pcwc, iord, irw, memr, memw, m2r, regw, rdst, asa, ext, ill;
    logic [1:0] pcs, asb, alu;
    logic fn_ok;
    {pcw, pcwc, iord, irw, memr, memw, m2r, regw, rdst, asa, ext, ill} = '0;
    pcs = 2'b00; asb = 2'b00; alu = 2'b00;
    fn_ok = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) || (fn == 6'b100101);
    case (st)
      4'd0: begin memr = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1: begin
        asb = 2'b11; ext = 1;
        ill = !((op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J) ||
                (op == OP_ADDI) || (op == OP_ORI) || ((op == OP_R) && fn_ok));
      end
      4'd2: begin asa = 1; asb = 2'b10; ext = 1; end
      4'd3: begin memr = 1; iord = 1; end
      4'd4: begin regw = 1; m2r = 1; rdst = 1; end
      4'd5: begin memw = 1; iord = 1; end
      4'd6: begin
        asa = 1;
        if (fn == 6'b100010) alu = 2'b01;
        else if (fn == 6'b100101) alu = 2'b10;
        else if (fn == 6'b100100) alu = 2'b11;
      end
      4'd7: regw = 1;
      4'd8: begin asa = 1; alu = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9: begin pcw = 1; pcs = 2'b10; end
      4'd10: begin
        asa = 1; asb = 2'b10;
        if (op == OP_ORI) begin ext = 0; alu = 2'b10; end
        else ext = 1;
      end
      4'd11: begin regw = 1; rdst = 1; end
      default: ;
    endcase
    return {pcw, pcwc, pcs, iord, irw, memr, memw, m2r, regw, rdst, asa, asb, ext, alu, ill};
  endfunction

  // Pushes the expected state walk of one instruction, then drives it cycle by
  // cycle, popping and checking each step. Entry: just after a rising edge, in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input int stall);
    step_t e;
    logic retired;
    sb_q.push_back('{4'd0, 1'b1, 1'b0});
    sb_q.push_back('{4'd1, 1'b1, 1'b0});
    case (op)
      OP_LW: begin
        sb_q.push_back('{4'd2, 1'b1, 1'b0});
        for (int i = 0; i < stall; i++) sb_q.push_back('{4'd3, 1'b0, 1'b0});
        sb_q.push_back('{4'd3, 1'b1, 1'b0});
        sb_q.push_back('{4'd4, 1'b1, 1'b1});
      end
      OP_SW: begin
        sb_q.push_back('{4'd2, 1'b1, 1'b0});
        for (int i = 0; i < stall; i++) sb_q.push_back('{4'd5, 1'b0, 1'b0});
        sb_q.push_back('{4'd5, 1'b1, 1'b1});
      end
      OP_BEQ: sb_q.push_back('{4'd8, 1'b1, 1'b1});
      OP_J:   sb_q.push_back('{4'd9, 1'b1, 1'b1});
      OP_ADDI, OP_ORI: begin
        sb_q.push_back('{4'd10, 1'b1, 1'b0});
        sb_q.push_back('{4'd11, 1'b1, 1'b1});
      end
      OP_R: begin
        if ((fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) || (fn == 6'b100101)) begin
          sb_q.push_back('{4'd6, 1'b1, 1'b0});
          sb_q.push_back('{4'd7, 1'b1, 1'b1});
        end
      end
      default: ;
    endcase
    retired = 1'b0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.OpCode = op; bus.funct = fn; bus.Zero = zero; bus.MemReady = e.mr;
      #1;
      checks++;
      if (bus.State !== e.st) begin
        errors++;
        $display("FAIL state op=%b: got %0d expected %0d", op, bus.State, e.st);
      end
      checks++;
      if (dut_vec !== model(e.st, op, fn, e.mr)) begin
        errors++;
        $display("FAIL outputs op=%b fn=%b st=%0d: got %b expected %b",
                 op, fn, e.st, dut_vec, model(e.st, op, fn, e.mr));
      end
      if (e.last_retire) retired = 1'b1;
      @(posedge Clk); #1;
    end
    if (retired) exp_cnt = exp_cnt + 1'b1;
    bus.MemReady = 1'b1;
    #1;
    checks++;
    if (bus.State !== 4'd0) begin
      errors++;
      $display("FAIL end_state op=%b: got %0d expected 0", op, bus.State);
    end
    checks++;
    if (bus.RetiredCnt !== exp_cnt) begin
      errors++;
      $display("FAIL retired op=%b: got %0d expected %0d", op, bus.RetiredCnt, exp_cnt);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; bus.OpCode = OP_SW; bus.funct = 6'd0; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    #2;
    checks++;
    if ({bus.State, bus.RetiredCnt, bus.IRWrite, bus.PcWrite} !== {4'd0, {CNT_W{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_init: got st=%0d cnt=%0d irw=%b pcw=%b expected 0 0 0 0",
               bus.State, bus.RetiredCnt, bus.IRWrite, bus.PcWrite);
    end
    @(posedge Clk); #1; Reset = 1'b0;
    // Walk a store into MEMWR and stall there.
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if ({bus.State, bus.MemW} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL memwr_stall: got st=%0d memw=%b expected 5 1", bus.State, bus.MemW);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({bus.State, bus.MemW} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_abort: got st=%0d memw=%b expected 0 0", bus.State, bus.MemW);
    end
    @(posedge Clk); #1; Reset = 1'b0;
    #1;
    checks++;
    if ({bus.State, bus.RetiredCnt, bus.IRWrite} !== {4'd0, {CNT_W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got st=%0d cnt=%0d irw=%b expected 0 0 0",
               bus.State, bus.RetiredCnt, bus.IRWrite);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.State !== 4'd0) begin
      errors++;
      $display("FAIL fetch_stall: got %0d expected 0", bus.State);
    end
    run_instr(OP_SW, 6'd0, 1'b0, 0);
  endtask

  task automatic test_load_stall;
    run_instr(OP_LW, 6'd0, 1'b0, 3);
  endtask

  task automatic test_rtype;
    run_instr(OP_R, 6'b100010, 1'b0, 0);
    run_instr(OP_R, 6'b100101, 1'b0, 0);
    run_instr(OP_R, 6'b100100, 1'b0, 0);
  endtask

  task automatic test_branch;
    run_instr(OP_BEQ, 6'd0, 1'b1, 0);
    run_instr(OP_BEQ, 6'd0, 1'b0, 0);
  endtask

  task automatic test_immediate;
    run_instr(OP_ORI, 6'd0, 1'b0, 0);
    run_instr(OP_ADDI, 6'd0, 1'b0, 0);
  endtask

  task automatic test_illegal;
    run_instr(6'b111111, 6'd0, 1'b0, 0);
    run_instr(OP_R, 6'b000000, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    run_instr(OP_J, 6'd0, 1'b0, 0);
    run_instr(OP_SW, 6'd0, 1'b0, 2);
    run_instr(OP_LW, 6'd0, 1'b0, 0);
  endtask

  task automatic test_wrap;
    int guard;
    guard = 0;
    while ((exp_cnt != {CNT_W{1'b1}}) && (guard < 40)) begin
      run_instr(OP_J, 6'd0, 1'b0, 0);
      guard++;
    end
    run_instr(OP_J, 6'd0, 1'b0, 0);
    checks++;
    if (bus.RetiredCnt !== {CNT_W{1'b0}}) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", bus.RetiredCnt);
    end
    run_instr(OP_J, 6'd0, 1'b0, 0);
    checks++;
    if (bus.RetiredCnt !== {{(CNT_W-1){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL wrap_one: got %0d expected 1", bus.RetiredCnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_stall();
    test_rtype();
    test_branch();
    test_immediate();
    test_illegal();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
